// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch control block.
// State encodings are visible on the state output, so the values are fixed.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StLap   = 2'd2,
        StPause = 2'd3
    } sw_state_e;

    localparam logic [15:0] BCD_ZERO = 16'h0000;

    function automatic logic is_bcd_zero(input logic [15:0] value);
        return value == BCD_ZERO;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer followed by a rising-edge detector.
// o_rise is high for one cycle once a new high level reaches the last sync stage.
module btn_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: run/pause, lap freeze, clear, count direction and
// down-count expiry, driven by four synchronized push-button events.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    input  logic        btn_dir,
    input  logic [15:0] digits,
    output logic        sw_enable,
    output logic        sw_up,
    output logic        sw_reset,
    output logic [15:0] disp_digits,
    output logic [1:0]  state,
    output logic        expired
);

    logic w_ev_ss, w_ev_lap, w_ev_clear, w_ev_dir;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .clk    (clk),
        .reset_n(reset_n),
        .i_btn  (btn_start_stop),
        .o_rise (w_ev_ss)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lap (
        .clk    (clk),
        .reset_n(reset_n),
        .i_btn  (btn_lap),
        .o_rise (w_ev_lap)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
        .clk    (clk),
        .reset_n(reset_n),
        .i_btn  (btn_clear),
        .o_rise (w_ev_clear)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
        .clk    (clk),
        .reset_n(reset_n),
        .i_btn  (btn_dir),
        .o_rise (w_ev_dir)
    );

    sw_state_e   r_state, w_state_next;
    logic        r_sw_up, w_sw_up_next;
    logic        r_done, w_done_next;
    logic [15:0] r_lap, w_lap_next;
    logic        r_sw_reset, w_sw_reset_next;

    logic w_active, w_settled, w_zero_down, w_expire;

    assign w_active    = (r_state == StRun) || (r_state == StLap);
    assign w_settled   = (r_state == StIdle) || (r_state == StPause);
    assign w_zero_down = !r_sw_up && is_bcd_zero(digits);
    assign w_expire    = w_active && w_zero_down;

    // Expiry outranks every button; below it only the top-priority event acts.
    always_comb begin
        w_state_next    = r_state;
        w_sw_up_next    = r_sw_up;
        w_done_next     = r_done;
        w_lap_next      = r_lap;
        w_sw_reset_next = 1'b0;
        if (w_expire) begin
            w_state_next = StIdle;
            w_done_next  = 1'b1;
        end else if (w_ev_clear) begin
            if (w_settled) begin
                w_state_next    = StIdle;
                w_done_next     = 1'b0;
                w_sw_reset_next = 1'b1;
            end
        end else if (w_ev_ss) begin
            case (r_state)
                StIdle:       if (!w_zero_down && !r_done) w_state_next = StRun;
                StRun, StLap: w_state_next = StPause;
                StPause:      if (!w_zero_down) w_state_next = StRun;
                default:      w_state_next = StIdle;
            endcase
        end else if (w_ev_lap) begin
            if (r_state == StRun) begin
                w_state_next = StLap;
                w_lap_next   = digits;
            end else if (r_state == StLap) begin
                w_state_next = StRun;
            end
        end else if (w_ev_dir) begin
            if (w_settled) w_sw_up_next = !r_sw_up;
        end
    end

    // sw_reset resets high so the stopwatch is held clear throughout reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_sw_up    <= 1'b1;
            r_done     <= 1'b0;
            r_lap      <= BCD_ZERO;
            r_sw_reset <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_sw_up    <= w_sw_up_next;
            r_done     <= w_done_next;
            r_lap      <= w_lap_next;
            r_sw_reset <= w_sw_reset_next;
        end
    end

    assign sw_enable   = w_active && !w_zero_down;
    assign expired     = w_expire;
    assign sw_up       = r_sw_up;
    assign sw_reset    = r_sw_reset;
    assign disp_digits = (r_state == StLap) ? r_lap : digits;
    assign state       = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a randomized
// run compared every cycle against a behavioural model of the control rules.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        btn_start_stop, btn_lap, btn_clear, btn_dir;
    logic [15:0] digits;
    logic        sw_enable, sw_up, sw_reset, expired;
    logic [15:0] disp_digits;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    localparam int B_SS = 0, B_LAP = 1, B_CLR = 2, B_DIR = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    always #5 clk = ~clk;

    stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_start_stop(btn_start_stop),
        .btn_lap       (btn_lap),
        .btn_clear     (btn_clear),
        .btn_dir       (btn_dir),
        .digits        (digits),
        .sw_enable     (sw_enable),
        .sw_up         (sw_up),
        .sw_reset      (sw_reset),
        .disp_digits   (disp_digits),
        .state         (state),
        .expired       (expired)
    );

    // Behavioural model: a button level first seen at edge k acts at edge k+2,
    // provided it was low at edge k-1.
    typedef struct {
        int          st;
        bit          up;
        bit          done;
        bit          clr;
        logic [15:0] lap;
    } mstate_t;

    mstate_t    m;
    logic [3:0] m_seen1, m_seen2, m_seen3;

    function automatic mstate_t model_next(input mstate_t c, input logic [3:0] ev,
                                           input logic [15:0] dig);
        mstate_t n;
        bit      zd;
        int      win;
        n     = c;
        n.clr = 1'b0;
        zd    = !c.up && (dig == 16'h0000);
        if ((c.st == M_RUN || c.st == M_LAP) && zd) begin
            n.st   = M_IDLE;
            n.done = 1'b1;
            return n;
        end
        win = ev[B_CLR] ? B_CLR : ev[B_SS] ? B_SS : ev[B_LAP] ? B_LAP : ev[B_DIR] ? B_DIR : -1;
        case (win)
            B_CLR: if (c.st == M_IDLE || c.st == M_PAUSE) begin
                n.st = M_IDLE; n.done = 1'b0; n.clr = 1'b1;
            end
            B_SS: begin
                if (c.st == M_RUN || c.st == M_LAP) n.st = M_PAUSE;
                else if (!zd && !(c.st == M_IDLE && c.done)) n.st = M_RUN;
            end
            B_LAP: begin
                if (c.st == M_RUN) begin n.st = M_LAP; n.lap = dig; end
                else if (c.st == M_LAP) n.st = M_RUN;
            end
            B_DIR: if (c.st == M_IDLE || c.st == M_PAUSE) n.up = !c.up;
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m       <= '{st: M_IDLE, up: 1'b1, done: 1'b0, clr: 1'b1, lap: 16'h0000};
            m_seen1 <= '0;
            m_seen2 <= '0;
            m_seen3 <= '0;
        end else begin
            m       <= model_next(m, m_seen2 & ~m_seen3, digits);
            m_seen3 <= m_seen2;
            m_seen2 <= m_seen1;
            m_seen1 <= {btn_dir, btn_clear, btn_lap, btn_start_stop};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int idx, input logic val);
        case (idx)
            B_SS:    btn_start_stop = val;
            B_LAP:   btn_lap = val;
            B_CLR:   btn_clear = val;
            default: btn_dir = val;
        endcase
    endtask

    // Returns just after the edge at which the press takes effect.
    task automatic pulse(input int idx);
        step();
        set_btn(idx, 1'b1);
        step();
        step();
        step();
        set_btn(idx, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0; btn_dir = 1'b0;
        digits = 16'h0000;
        step();
        step();
        n_checks++; if (state !== 2'd0) begin n_errors++;
            $display("FAIL reset_state got=%0d exp=0", state); end
        n_checks++; if (sw_up !== 1'b1) begin n_errors++;
            $display("FAIL reset_sw_up got=%b exp=1", sw_up); end
        n_checks++; if (sw_reset !== 1'b1) begin n_errors++;
            $display("FAIL reset_sw_reset got=%b exp=1", sw_reset); end
        n_checks++; if (sw_enable !== 1'b0 || expired !== 1'b0) begin n_errors++;
            $display("FAIL reset_en_exp got=%b%b exp=00", sw_enable, expired); end
        reset_n = 1'b1;
        step();
        n_checks++; if (sw_reset !== 1'b0) begin n_errors++;
            $display("FAIL reset_release_sw_reset got=%b exp=0", sw_reset); end
    endtask

    task automatic test_start();
        step();
        btn_start_stop = 1'b1;
        step();
        step();
        n_checks++; if (state !== 2'd0) begin n_errors++;
            $display("FAIL start_early state got=%0d exp=0", state); end
        step();
        btn_start_stop = 1'b0;
        n_checks++; if (state !== 2'd1) begin n_errors++;
            $display("FAIL start_run state got=%0d exp=1", state); end
        n_checks++; if (sw_enable !== 1'b1 || sw_up !== 1'b1) begin n_errors++;
            $display("FAIL start_outputs en,up got=%b%b exp=11", sw_enable, sw_up); end
    endtask

    task automatic test_lap();
        digits = 16'h0042;
        pulse(B_LAP);
        digits = 16'h0057;
        #1;
        n_checks++; if (state !== 2'd2) begin n_errors++;
            $display("FAIL lap_state got=%0d exp=2", state); end
        n_checks++; if (disp_digits !== 16'h0042) begin n_errors++;
            $display("FAIL lap_frozen disp got=%h exp=0042", disp_digits); end
        pulse(B_LAP);
        n_checks++; if (state !== 2'd1 || disp_digits !== 16'h0057) begin n_errors++;
            $display("FAIL lap_release state,disp got=%0d,%h exp=1,0057", state, disp_digits); end
    endtask

    task automatic test_countdown();
        pulse(B_SS);
        digits = 16'h0003;
        n_checks++; if (state !== 2'd3) begin n_errors++;
            $display("FAIL cd_pause state got=%0d exp=3", state); end
        pulse(B_DIR);
        n_checks++; if (sw_up !== 1'b0) begin n_errors++;
            $display("FAIL cd_dir sw_up got=%b exp=0", sw_up); end
        pulse(B_SS);
        n_checks++; if (state !== 2'd1 || sw_enable !== 1'b1) begin n_errors++;
            $display("FAIL cd_resume state,en got=%0d,%b exp=1,1", state, sw_enable); end
        digits = 16'h0002;
        step();
        digits = 16'h0001;
        step();
        digits = 16'h0000;
        #1;
        n_checks++; if (expired !== 1'b1 || sw_enable !== 1'b0) begin n_errors++;
            $display("FAIL cd_expire exp,en got=%b%b exp=10", expired, sw_enable); end
        step();
        n_checks++; if (state !== 2'd0 || expired !== 1'b0) begin n_errors++;
            $display("FAIL cd_idle state,exp got=%0d,%b exp=0,0", state, expired); end
        digits = 16'h0005;
        pulse(B_SS);
        n_checks++; if (state !== 2'd0) begin n_errors++;
            $display("FAIL cd_done_blocks state got=%0d exp=0", state); end
        pulse(B_CLR);
        n_checks++; if (sw_reset !== 1'b1 || sw_up !== 1'b0) begin n_errors++;
            $display("FAIL cd_clear rst,up got=%b%b exp=10", sw_reset, sw_up); end
        step();
        n_checks++; if (sw_reset !== 1'b0) begin n_errors++;
            $display("FAIL cd_clear_width sw_reset got=%b exp=0", sw_reset); end
        pulse(B_SS);
        n_checks++; if (state !== 2'd1) begin n_errors++;
            $display("FAIL cd_after_clear state got=%0d exp=1", state); end
        pulse(B_SS);
        pulse(B_CLR);
    endtask

    task automatic test_idle_zero();
        digits = 16'h0000;
        pulse(B_SS);
        step();
        n_checks++; if (state !== 2'd0 || sw_enable !== 1'b0) begin n_errors++;
            $display("FAIL idle_zero state,en got=%0d,%b exp=0,0", state, sw_enable); end
    endtask

    task automatic test_clear_priority();
        digits = 16'h0007;
        pulse(B_SS);
        pulse(B_SS);
        n_checks++; if (state !== 2'd3) begin n_errors++;
            $display("FAIL prio_pause state got=%0d exp=3", state); end
        step();
        btn_clear = 1'b1;
        btn_start_stop = 1'b1;
        step();
        step();
        step();
        btn_clear = 1'b0;
        btn_start_stop = 1'b0;
        n_checks++; if (sw_reset !== 1'b1 || state !== 2'd0) begin n_errors++;
            $display("FAIL prio_clear rst,state got=%b,%0d exp=1,0", sw_reset, state); end
        step();
        step();
        n_checks++; if (sw_reset !== 1'b0 || state !== 2'd0) begin n_errors++;
            $display("FAIL prio_no_run rst,state got=%b,%0d exp=0,0", sw_reset, state); end
    endtask

    task automatic test_reset_mid_lap();
        pulse(B_DIR);
        digits = 16'h0123;
        pulse(B_SS);
        pulse(B_LAP);
        digits = 16'h0456;
        #1;
        n_checks++; if (state !== 2'd2 || disp_digits !== 16'h0123) begin n_errors++;
            $display("FAIL mid_lap state,disp got=%0d,%h exp=2,0123", state, disp_digits); end
        reset_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0 || sw_up !== 1'b1 || sw_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_lap_reset state,up,rst got=%0d,%b,%b exp=0,1,1",
                     state, sw_up, sw_reset); end
        n_checks++; if (disp_digits !== 16'h0456 || sw_enable !== 1'b0) begin n_errors++;
            $display("FAIL mid_lap_reset disp,en got=%h,%b exp=0456,0", disp_digits, sw_enable); end
        reset_n = 1'b1;
        step();
        btn_start_stop = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        btn_start_stop = 1'b0;
        step();
        step();
        step();
        n_checks++; if (state !== 2'd0) begin n_errors++;
            $display("FAIL inflight_reset state got=%0d exp=0", state); end
    endtask

    task automatic test_random();
        bit zd, act;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 149) == 0) reset_n = 1'b0;
            if ($urandom_range(0, 3) == 0) btn_start_stop = ~btn_start_stop;
            if ($urandom_range(0, 3) == 0) btn_lap = ~btn_lap;
            if ($urandom_range(0, 5) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 4) == 0) btn_dir = ~btn_dir;
            case ($urandom_range(0, 3))
                0, 1:    digits = 16'h0000;
                2:       digits = 16'h0001;
                default: digits = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            endcase
            #1;
            act = (m.st == M_RUN) || (m.st == M_LAP);
            zd  = !m.up && (digits == 16'h0000);
            n_checks++; if (state !== 2'(m.st)) begin n_errors++;
                $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", cyc, state, m.st); end
            n_checks++; if (sw_up !== m.up) begin n_errors++;
                $display("FAIL rand_sw_up cyc=%0d got=%b exp=%b", cyc, sw_up, m.up); end
            n_checks++; if (sw_reset !== m.clr) begin n_errors++;
                $display("FAIL rand_sw_reset cyc=%0d got=%b exp=%b", cyc, sw_reset, m.clr); end
            n_checks++; if (sw_enable !== (act && !zd)) begin n_errors++;
                $display("FAIL rand_sw_enable cyc=%0d got=%b exp=%b", cyc, sw_enable,
                         act && !zd); end
            n_checks++; if (expired !== (act && zd)) begin n_errors++;
                $display("FAIL rand_expired cyc=%0d got=%b exp=%b", cyc, expired, act && zd); end
            n_checks++;
            if (disp_digits !== ((m.st == M_LAP) ? m.lap : digits)) begin n_errors++;
                $display("FAIL rand_disp cyc=%0d got=%h exp=%h", cyc, disp_digits,
                         (m.st == M_LAP) ? m.lap : digits); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_lap();
        test_countdown();
        test_idle_zero();
        test_clear_priority();
        test_reset_mid_lap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per button input (minimum 2).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 btn_start_stop  input  1  asynchronous debounced level; rising edge toggles run/pause.
REQ-005 btn_lap  input  1  asynchronous debounced level; rising edge toggles lap freeze.
REQ-006 btn_clear  input  1  asynchronous debounced level; rising edge requests counter clear.
REQ-007 btn_dir  input  1  asynchronous debounced level; rising edge toggles count direction.
REQ-008 digits  input  16  live BCD count from stopwatch, {d3,d2,d1,d0}.
REQ-009 sw_enable  output  1  count enable to stopwatch.
REQ-010 sw_up  output  1  direction to stopwatch, 1 = up.
REQ-011 sw_reset  output  1  active-high synchronous clear to stopwatch.
REQ-012 disp_digits  output  16  BCD value for display, live or lap-frozen.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 expired  output  1  one-cycle pulse when a down-count reaches 0000.

Function
REQ-015 Each btn_* SHALL pass through SYNC_STAGES flops, then a rising-edge detector producing a one-cycle event.
REQ-016 With SYNC_STAGES=2, state SHALL update on the 3rd rising clk edge after a button is first sampled high.
REQ-017 FSM states SHALL be IDLE=0, RUN=1, LAP=2, PAUSE=3 (wait: see REQ-018 for DONE handling).
REQ-018 Down-count expiry SHALL return to IDLE with a done flag register set; done cleared only by clear event.
REQ-019 Event priority within one cycle SHALL be clear > start_stop > lap > dir; lower-priority events that cycle SHALL be discarded.
REQ-020 IDLE + start_stop -> RUN, unless sw_up=0 and digits==0000 or done=1 (then ignored).
REQ-021 RUN + start_stop -> PAUSE; LAP + start_stop -> PAUSE (freeze released).
REQ-022 PAUSE + start_stop -> RUN, unless sw_up=0 and digits==0000 (ignored).
REQ-023 RUN + lap -> LAP, capturing digits into lap register on that edge; LAP + lap -> RUN; lap ignored in IDLE/PAUSE.
REQ-024 clear in IDLE or PAUSE -> IDLE, sw_reset high exactly one cycle, done cleared, sw_up unchanged; clear ignored in RUN/LAP.
REQ-025 dir toggles sw_up only in IDLE or PAUSE; ignored in RUN/LAP.
REQ-026 sw_enable SHALL be combinational: (state==RUN or LAP) and not (sw_up==0 and digits==0000).
REQ-027 In RUN/LAP with sw_up=0, first cycle digits==0000 SHALL pulse expired for one cycle and move to IDLE with done=1 on the next edge.
REQ-028 disp_digits SHALL equal lap register in LAP, else digits (combinational).
REQ-029 Up-count wrap 9999->0000 SHALL NOT stop counting or pulse expired.

Reset
REQ-030 reset_n low SHALL asynchronously force state=IDLE, sw_up=1, done=0, lap register=0000, all synchronizer/edge flops=0.
REQ-031 While reset_n low, sw_reset=1, sw_enable=0, expired=0.
REQ-032 Reset mid-RUN SHALL abort immediately; no button event in flight SHALL survive reset.

Structure
REQ-033 Shared package stopwatch_ctrl_pkg SHALL hold state encodings and BCD_ZERO (16'h0000).
REQ-034 Sub-module btn_sync_edge (synchronizer + rising-edge detect, parameter SYNC_STAGES) SHALL be instantiated four times.

Verification
REQ-035 Reset, then start_stop pulse -> state RUN 3 clks after sampling, sw_enable=1, sw_up=1.
REQ-036 RUN with digits=0042, lap pulse, digits driven to 0057 -> disp_digits=0042; second lap -> disp_digits=0057.
REQ-037 PAUSE at 0003, dir pulse -> sw_up=0; start_stop; digits stepped 0002,0001,0000 -> expired one cycle, sw_enable=0 same cycle, IDLE with done=1.
REQ-038 IDLE, sw_up=0, digits=0000, start_stop -> stays IDLE, sw_enable=0.
REQ-039 clear and start_stop edges same cycle in PAUSE -> sw_reset one cycle, state IDLE, no RUN.
REQ-040 reset_n asserted mid-LAP -> state IDLE, sw_up=1, sw_reset=1, disp_digits=digits immediately.
